// File: rtl/program_loader_if.sv
// Boot loader bus bundle: byte stream into the loader (valid/ready) and the
// instruction-memory write port out of it.
//   inValid/inByte   : stream source -> loader
//   inReady          : loader -> stream source
//   imemWriteEnable  : one-cycle write strobe per assembled word
//   imemAddr         : word-aligned byte address of the write
//   imemWriteData    : assembled big-endian instruction word
// master = loader side, slave = stream source / instruction memory side.
interface program_loader_if;
  logic        inValid;
  logic [7:0]  inByte;
  logic        inReady;
  logic        imemWriteEnable;
  logic [31:0] imemAddr;
  logic [31:0] imemWriteData;

  modport master (
    input  inValid, inByte,
    output inReady, imemWriteEnable, imemAddr, imemWriteData
  );

  modport slave (
    output inValid, inByte,
    input  inReady, imemWriteEnable, imemAddr, imemWriteData
  );
endinterface

// File: rtl/program_loader.sv
// Boot-time instruction-memory writer. Receives a framed byte stream
// (LEN_HI, LEN_LO, 4*N data bytes MSB first, XOR checksum of data bytes),
// writes each assembled word to consecutive addresses from BASE_ADDR and
// releases the CPU only after the checksum matches.
//   clock      : system clock, rising edge
//   resetN     : asynchronous active-low reset
//   start      : load request pulse, honoured in IDLE, DONE and ERR
//   bus        : stream in / imem write out (program_loader_if.master)
//   cpuHold    : freezes the CPU PC while high
//   done       : last load completed with matching checksum
//   error      : last load aborted (bad length or checksum)
//   wordCount  : word count of the last successful load
//
// state   | meaning
// --------+------------------------------------------------------
// IDLE    | after reset, waiting for start
// LEN_HI  | waiting for word-count high byte
// LEN_LO  | waiting for word-count low byte, length is judged here
// DATA    | shifting data bytes into the word register
// WRITE   | single cycle with the imem write strobe high
// CHECK   | waiting for the checksum byte
// DONE    | load good, CPU released
// ERR     | load aborted, CPU held, written words left in place
module program_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic             start,
  program_loader_if.master bus,
  output logic             cpuHold,
  output logic             done,
  output logic             error,
  output logic [15:0]      wordCount
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_CHECK, S_DONE, S_ERR
  } state_t;

  // One extra bit so a MAX_WORDS of 65535 or more still compares cleanly.
  localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

  state_t      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] word_idx_q, word_idx_d;
  logic [15:0] wcount_q, wcount_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [7:0]  chk_q, chk_d;
  logic [31:0] word_q, word_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        hold_q, hold_d;
  logic        done_q, done_d;
  logic        error_q, error_d;

  logic        accept;
  logic [15:0] len_full;
  logic [15:0] idx_next;

  assign bus.inReady = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                       (state_q == S_DATA)   || (state_q == S_CHECK);
  assign accept   = bus.inValid && bus.inReady;
  assign len_full = {len_q[15:8], bus.inByte};
  assign idx_next = word_idx_q + 16'd1;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      word_idx_q <= '0;
      wcount_q   <= '0;
      byte_idx_q <= '0;
      chk_q      <= '0;
      word_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      hold_q     <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_idx_q <= word_idx_d;
      wcount_q   <= wcount_d;
      byte_idx_q <= byte_idx_d;
      chk_q      <= chk_d;
      word_q     <= word_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  // Outputs are registered: each one is set on the transition into the
  // state that owns it, so it is valid for the whole of that state.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_idx_d = word_idx_q;
    wcount_d   = wcount_q;
    byte_idx_d = byte_idx_q;
    chk_d      = chk_q;
    word_d     = word_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = 1'b0;
    hold_d     = hold_q;
    done_d     = done_q;
    error_d    = error_q;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (accept) begin
          len_d   = {bus.inByte, len_q[7:0]};
          state_d = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          len_d      = len_full;
          byte_idx_d = '0;
          word_idx_d = '0;
          chk_d      = '0;
          if ({1'b0, len_full} > MAX_W) begin
            state_d = S_ERR;
            error_d = 1'b1;
            hold_d  = 1'b1;
            done_d  = 1'b0;
          end else if (len_full == 16'd0) begin
            state_d = S_CHECK;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          word_d = {word_q[23:0], bus.inByte};
          chk_d  = chk_q ^ bus.inByte;
          if (byte_idx_q == 2'd3) begin
            byte_idx_d = '0;
            state_d    = S_WRITE;
            we_d       = 1'b1;
            addr_d     = BASE_ADDR + {14'd0, word_idx_q, 2'b00};
            wdata_d    = word_d;
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end
      end
      S_WRITE: begin
        word_idx_d = idx_next;
        state_d    = (idx_next == len_q) ? S_CHECK : S_DATA;
      end
      S_CHECK: begin
        if (accept) begin
          if (bus.inByte == chk_q) begin
            state_d  = S_DONE;
            done_d   = 1'b1;
            hold_d   = 1'b0;
            wcount_d = len_q;
          end else begin
            state_d = S_ERR;
            error_d = 1'b1;
            hold_d  = 1'b1;
            done_d  = 1'b0;
          end
        end
      end
      S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_LEN_HI;
          done_d  = 1'b0;
          error_d = 1'b0;
          hold_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.imemWriteEnable = we_q;
  assign bus.imemAddr        = addr_q;
  assign bus.imemWriteData   = wdata_q;
  assign cpuHold             = hold_q;
  assign done                = done_q;
  assign error               = error_q;
  assign wordCount           = wcount_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: nominal load, bad checksum, length
// boundaries, backpressure with gaps, mid-load reset and start filtering.
module tb_program_loader;
  logic        clock = 1'b0;
  logic        resetN;
  logic        start;
  logic        cpuHold;
  logic        done;
  logic        error;
  logic [15:0] wordCount;

  program_loader_if bus();

  program_loader #(
    .BASE_ADDR(32'h0000_0000),
    .MAX_WORDS(256)
  ) dut (
    .clock     (clock),
    .resetN    (resetN),
    .start     (start),
    .bus       (bus),
    .cpuHold   (cpuHold),
    .done      (done),
    .error     (error),
    .wordCount (wordCount)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [63:0] wr_q[$];
  logic [7:0]  cons_q[$];
  logic [7:0]  fr[$];
  logic [7:0]  nominal[$];

  localparam logic [63:0] W0 = {32'h0000_0000, 32'h2008_0005};
  localparam logic [63:0] W1 = {32'h0000_0004, 32'h8C09_0004};

  // Write strobes and consumed bytes, sampled mid-cycle.
  always @(negedge clock) begin
    if (bus.imemWriteEnable === 1'b1)
      wr_q.push_back({bus.imemAddr, bus.imemWriteData});
    if (resetN === 1'b1 && bus.inValid === 1'b1 && bus.inReady === 1'b1)
      cons_q.push_back(bus.inByte);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  // Present one byte and hold it until a cycle with inReady high has passed.
  // inValid is left high so back-to-back bytes form a continuous stream.
  task automatic send_byte(input logic [7:0] b);
    bit acc = 1'b0;
    int n = 0;
    bus.inByte  = b;
    bus.inValid = 1'b1;
    while (!acc && n < 40) begin
      @(negedge clock);
      acc = (bus.inReady === 1'b1);
      @(posedge clock);
      #1;
      n++;
    end
    chk("byte_accept", 64'(acc), 64'd1);
  endtask

  task automatic send_frame(input bit gaps);
    int k;
    foreach (fr[i]) begin
      if (gaps) begin
        k = $urandom_range(0, 2);
        if (k > 0) begin
          bus.inValid = 1'b0;
          step(k);
        end
      end
      send_byte(fr[i]);
    end
    bus.inValid = 1'b0;
  endtask

  task automatic check_nominal_writes(input string tag);
    chk({tag, "_nwr"}, 64'(wr_q.size()), 64'd2);
    if (wr_q.size() >= 2) begin
      chk({tag, "_w0"}, wr_q[0], W0);
      chk({tag, "_w1"}, wr_q[1], W1);
    end
  endtask

  task automatic check_done(input string tag, input logic [15:0] wc);
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_error"}, 64'(error), 64'd0);
    chk({tag, "_hold"}, 64'(cpuHold), 64'd0);
    chk({tag, "_wcount"}, 64'(wordCount), 64'(wc));
  endtask

  initial begin
    nominal = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                8'h8C, 8'h09, 8'h00, 8'h04, 8'hAC};
    resetN      = 1'b0;
    start       = 1'b0;
    bus.inValid = 1'b0;
    bus.inByte  = 8'h00;
    step(2);

    // Reset state
    chk("rst_hold",   64'(cpuHold), 64'd1);
    chk("rst_ready",  64'(bus.inReady), 64'd0);
    chk("rst_we",     64'(bus.imemWriteEnable), 64'd0);
    chk("rst_addr",   64'(bus.imemAddr), 64'd0);
    chk("rst_wdata",  64'(bus.imemWriteData), 64'd0);
    chk("rst_done",   64'(done), 64'd0);
    chk("rst_error",  64'(error), 64'd0);
    chk("rst_wcount", 64'(wordCount), 64'd0);
    resetN = 1'b1;
    step(2);
    chk("idle_ready", 64'(bus.inReady), 64'd0);

    // 1. Nominal load, strobe the cycle after each word's 4th byte
    wr_q.delete();
    pulse_start();
    chk("s1_ready_lenhi", 64'(bus.inReady), 64'd1);
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h20); send_byte(8'h08); send_byte(8'h00); send_byte(8'h05);
    chk("s1_we0",   64'(bus.imemWriteEnable), 64'd1);
    chk("s1_addr0", 64'(bus.imemAddr), 64'h0);
    chk("s1_data0", 64'(bus.imemWriteData), 64'h2008_0005);
    chk("s1_ready_write", 64'(bus.inReady), 64'd0);
    send_byte(8'h8C); send_byte(8'h09); send_byte(8'h00); send_byte(8'h04);
    chk("s1_we1",   64'(bus.imemWriteEnable), 64'd1);
    chk("s1_addr1", 64'(bus.imemAddr), 64'h4);
    chk("s1_data1", 64'(bus.imemWriteData), 64'h8C09_0004);
    send_byte(8'hAC);
    bus.inValid = 1'b0;
    chk("s1_we_off", 64'(bus.imemWriteEnable), 64'd0);
    check_done("s1", 16'd2);
    check_nominal_writes("s1");

    // 2. Bad checksum, then recovery
    wr_q.delete();
    pulse_start();
    chk("s2_restart_done", 64'(done), 64'd0);
    chk("s2_restart_hold", 64'(cpuHold), 64'd1);
    fr = nominal;
    fr[10] = 8'h00;
    send_frame(1'b0);
    check_nominal_writes("s2");
    chk("s2_error",  64'(error), 64'd1);
    chk("s2_done",   64'(done), 64'd0);
    chk("s2_hold",   64'(cpuHold), 64'd1);
    chk("s2_ready",  64'(bus.inReady), 64'd0);
    chk("s2_wcount", 64'(wordCount), 64'd2);
    wr_q.delete();
    pulse_start();
    chk("s2_restart_error", 64'(error), 64'd0);
    fr = nominal;
    send_frame(1'b0);
    check_nominal_writes("s2r");
    check_done("s2r", 16'd2);

    // 3. Length boundaries
    wr_q.delete();
    pulse_start();
    fr = '{8'h00, 8'h00, 8'h00};
    send_frame(1'b0);
    check_done("s3z", 16'd0);
    chk("s3z_nwr", 64'(wr_q.size()), 64'd0);

    pulse_start();
    send_byte(8'h01); send_byte(8'h01);
    chk("s3big_error", 64'(error), 64'd1);
    chk("s3big_ready", 64'(bus.inReady), 64'd0);
    chk("s3big_wcount", 64'(wordCount), 64'd0);
    cons_q.delete();
    bus.inByte = 8'hAA;
    step(4);
    bus.inValid = 1'b0;
    chk("s3big_noconsume", 64'(cons_q.size()), 64'd0);

    pulse_start();
    send_byte(8'h01); send_byte(8'h00);
    bus.inValid = 1'b0;
    chk("s3max_error", 64'(error), 64'd0);
    chk("s3max_ready", 64'(bus.inReady), 64'd1);
    step(2);
    chk("s3max_stay", 64'(bus.inReady), 64'd1);
    resetN = 1'b0;
    step(1);
    resetN = 1'b1;
    step(1);

    // 4. Continuous inValid, then random gaps
    wr_q.delete();
    cons_q.delete();
    pulse_start();
    fr = nominal;
    send_frame(1'b0);
    check_nominal_writes("s4");
    check_done("s4", 16'd2);
    chk("s4_ncons", 64'(cons_q.size()), 64'd11);
    for (int i = 0; i < 11; i++)
      if (i < cons_q.size()) chk("s4_cons", 64'(cons_q[i]), 64'(nominal[i]));

    wr_q.delete();
    cons_q.delete();
    pulse_start();
    send_frame(1'b1);
    check_nominal_writes("s4g");
    check_done("s4g", 16'd2);
    chk("s4g_ncons", 64'(cons_q.size()), 64'd11);

    // 5. Reset mid-DATA
    wr_q.delete();
    pulse_start();
    for (int i = 0; i < 5; i++) send_byte(nominal[i]);
    bus.inByte = nominal[5];
    @(negedge clock);
    #2;
    resetN = 1'b0;
    #1;
    chk("s5_hold",   64'(cpuHold), 64'd1);
    chk("s5_ready",  64'(bus.inReady), 64'd0);
    chk("s5_we",     64'(bus.imemWriteEnable), 64'd0);
    chk("s5_addr",   64'(bus.imemAddr), 64'd0);
    chk("s5_wdata",  64'(bus.imemWriteData), 64'd0);
    chk("s5_done",   64'(done), 64'd0);
    chk("s5_wcount", 64'(wordCount), 64'd0);
    step(2);
    chk("s5_nwr", 64'(wr_q.size()), 64'd0);
    bus.inByte = 8'h00;
    resetN = 1'b1;
    cons_q.delete();
    step(3);
    chk("s5_stall", 64'(cons_q.size()), 64'd0);
    pulse_start();
    fr = nominal;
    send_frame(1'b0);
    check_nominal_writes("s5");
    check_done("s5", 16'd2);
    chk("s5_ncons", 64'(cons_q.size()), 64'd11);

    // 6. Start filtering
    wr_q.delete();
    pulse_start();
    send_byte(8'h00);
    bus.inValid = 1'b0;
    pulse_start();
    chk("s6_lenlo_ready", 64'(bus.inReady), 64'd1);
    send_byte(8'h02); send_byte(8'h20); send_byte(8'h08);
    bus.inValid = 1'b0;
    pulse_start();
    chk("s6_data_ready", 64'(bus.inReady), 64'd1);
    for (int i = 4; i < 11; i++) send_byte(nominal[i]);
    bus.inValid = 1'b0;
    check_nominal_writes("s6");
    check_done("s6", 16'd2);
    pulse_start();
    chk("s6_restart_done",  64'(done), 64'd0);
    chk("s6_restart_hold",  64'(cpuHold), 64'd1);
    chk("s6_restart_ready", 64'(bus.inReady), 64'd1);
    chk("s6_restart_wcount", 64'(wordCount), 64'd2);

    step(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
